// File: rtl/kgp_boot_pkg.sv
// Shared definitions for the KGP boot loader: loader states, word geometry
// and the running-checksum step applied to every data byte of a frame.
package kgp_boot_pkg;

    localparam int BYTES_PER_WORD = 4;

    localparam logic [2:0] ST_LEN_C   = 3'd0;
    localparam logic [2:0] ST_DATA_C  = 3'd1;
    localparam logic [2:0] ST_SUM_C   = 3'd2;
    localparam logic [2:0] ST_HOLD_C  = 3'd3;
    localparam logic [2:0] ST_RUN_C   = 3'd4;
    localparam logic [2:0] ST_ERROR_C = 3'd5;

    typedef enum logic [2:0] {
        ST_LEN   = ST_LEN_C,
        ST_DATA  = ST_DATA_C,
        ST_SUM   = ST_SUM_C,
        ST_HOLD  = ST_HOLD_C,
        ST_RUN   = ST_RUN_C,
        ST_ERROR = ST_ERROR_C
    } boot_state_e;

    function automatic logic [7:0] checksum_step(input logic [7:0] acc,
                                                 input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/kgp_boot_loader_packer.sv
// Byte-to-word packer: keeps the last three bytes of the current word and
// presents the completed big-endian word combinationally with its 4th byte.
module boot_word_packer
    import kgp_boot_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [7:0]                    byte_in_i,
    input  logic                          byte_vld_i,
    input  logic                          clear_i,
    output logic [8*BYTES_PER_WORD-1:0]   word_out_o,
    output logic                          word_vld_o
);

    localparam int LANES = BYTES_PER_WORD - 1;
    localparam int CNT_W = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [8*LANES-1:0] shift_q;
    logic [8*LANES-1:0] shift_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    // Lane 0 holds the newest byte; older bytes move toward the MSB end.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            if (gi == 0) begin : g_head
                assign shift_d[7:0] = byte_in_i;
            end else begin : g_tail
                assign shift_d[8*gi +: 8] = shift_q[8*(gi-1) +: 8];
            end
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (byte_vld_i) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (clear_i) begin
                shift_q <= '0;
            end else if (byte_vld_i) begin
                shift_q <= shift_d;
            end
        end
    end

    assign word_out_o = {shift_q, byte_in_i};
    assign word_vld_o = byte_vld_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/kgp_boot_loader.sv
// Boot loader for the KGP_RISC core: receives a LEN/DATA/SUM byte frame,
// writes the packed words to instruction memory and releases the core only
// after the checksum matches.
module kgp_boot_loader
    import kgp_boot_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    input  logic              reload_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_reset_o,
    output logic              load_done_o,
    output logic              load_err_o
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int WCNT_W = ADDR_W + 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WORD_ONE  = WCNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    boot_state_e       state_q, state_d;
    logic [WCNT_W-1:0] n_q, n_d;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]        xor_q, xor_d;

    logic              rx_ready_q, rx_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;

    logic              byte_acc;
    logic              len_ok;
    logic              last_word;
    logic              pk_byte_vld;
    logic              pk_clear;
    logic [31:0]       pk_word;
    logic              pk_word_vld;

    assign byte_acc    = rx_valid_i && rx_ready_q;
    assign len_ok      = (rx_data_i != 8'd0) && (int'(rx_data_i) <= DEPTH);
    assign last_word   = ((word_cnt_q + WORD_ONE) == n_q);
    // A reload in the same cycle as an accepted byte wins; the byte is dropped.
    assign pk_byte_vld = byte_acc && (state_q == ST_DATA) && !reload_i;
    assign pk_clear    = reload_i || (byte_acc && (state_q == ST_LEN));

    boot_word_packer u_packer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .byte_in_i  (rx_data_i),
        .byte_vld_i (pk_byte_vld),
        .clear_i    (pk_clear),
        .word_out_o (pk_word),
        .word_vld_o (pk_word_vld)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        hold_cnt_d = hold_cnt_q;
        xor_d      = xor_q;

        if (reload_i) begin
            state_d    = ST_LEN;
            n_d        = '0;
            word_cnt_d = '0;
            hold_cnt_d = '0;
            xor_d      = '0;
        end else begin
            case (state_q)
                ST_LEN: begin
                    if (byte_acc) begin
                        if (len_ok) begin
                            n_d        = WCNT_W'(rx_data_i);
                            word_cnt_d = '0;
                            xor_d      = '0;
                            state_d    = ST_DATA;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end
                end
                ST_DATA: begin
                    if (byte_acc) begin
                        xor_d = checksum_step(xor_q, rx_data_i);
                        if (pk_word_vld) begin
                            word_cnt_d = word_cnt_q + WORD_ONE;
                            if (last_word) begin
                                state_d = ST_SUM;
                            end
                        end
                    end
                end
                ST_SUM: begin
                    if (byte_acc) begin
                        hold_cnt_d = '0;
                        state_d    = (rx_data_i == xor_q) ? ST_HOLD : ST_ERROR;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_ONE;
                    end
                end
                ST_RUN, ST_ERROR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_LEN;
                end
            endcase
        end

        // Every output is a function of the next state so it is registered.
        rx_ready_d   = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_SUM);
        imem_we_d    = pk_word_vld;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        if (pk_word_vld) begin
            imem_addr_d  = word_cnt_q[ADDR_W-1:0];
            imem_wdata_d = pk_word;
        end
        cpu_reset_d = (state_d != ST_RUN);
        load_done_d = (state_d == ST_RUN);
        load_err_d  = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_LEN;
            n_q          <= '0;
            word_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            xor_q        <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            word_cnt_q   <= word_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            xor_q        <= xor_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    assign rx_ready_o   = rx_ready_q;
    assign imem_we_o    = imem_we_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_wdata_o = imem_wdata_q;
    assign cpu_reset_o  = cpu_reset_q;
    assign load_done_o  = load_done_q;
    assign load_err_o   = load_err_q;

endmodule

// File: tb/tb_kgp_boot_loader.sv
// Self-checking bench for kgp_boot_loader: table-driven frames, hand-written
// reset/reload sequences and randomized frames against a frame-level model.
module tb_kgp_boot_loader;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              reload = 1'b0;
    logic              rx_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_wdata_o;
    logic              cpu_reset_o;
    logic              load_done_o;
    logic              load_err_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [7:0]  len;
        logic [31:0] seed;
        logic [31:0] step;
        logic [7:0]  flip;
        bit          gaps;
        bit          exp_run;
    } vec_t;
    vec_t vecs[7];

    logic [31:0] frame_words [DEPTH];

    kgp_boot_loader #(.ADDR_W(ADDR_W), .HOLD_CYCLES(2)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .rx_ready_o   (rx_ready_o),
        .reload_i     (reload),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .cpu_reset_o  (cpu_reset_o),
        .load_done_o  (load_done_o),
        .load_err_o   (load_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Write monitor: every strobe must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (rst_n && imem_we_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", imem_addr_o, imem_wdata_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chkw("wr_addr", 32'(imem_addr_o), 32'(e.addr));
                chkw("wr_data", imem_wdata_o, e.data);
                chkw("wr_cycle", 32'(cyc), 32'(e.cyc));
                $display("write addr=%0d data=%h cycle=%0d", imem_addr_o, imem_wdata_o, cyc);
            end
        end
    end

    function automatic logic [7:0] model_sum(input int n);
        logic [7:0] s = 8'h00;
        for (int k = 0; k < n; k++)
            for (int b = 0; b < 4; b++)
                s = s ^ frame_words[k][8*b +: 8];
        return s;
    endfunction

    task automatic fill_words(input logic [31:0] seed, input logic [31:0] step);
        for (int k = 0; k < DEPTH; k++) frame_words[k] = seed + 32'(k) * step;
    endtask

    // Called just after a rising edge; returns just after the edge that took the byte.
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit word_end,
                             input int widx, input logic [31:0] wval);
        bit done = 1'b0;
        rx_data = b;
        for (int t = 0; t < 400 && !done; t++) begin
            rx_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (rx_valid && rx_ready_o) begin
                done = 1'b1;
                if (word_end) exp_q.push_back('{5'(widx), wval, cyc + 1});
            end
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte %h not accepted within 400 cycles", b);
        end
    endtask

    task automatic send_frame(input logic [7:0] len, input logic [7:0] flip,
                              input bit gaps, input bit exp_run, input string tag);
        bit ok_len;
        ok_len = (len >= 8'd1) && (int'(len) <= DEPTH);
        send_byte(len, gaps, 1'b0, 0, 32'h0);
        if (ok_len) begin
            for (int k = 0; k < int'(len); k++)
                for (int b = 0; b < 4; b++)
                    send_byte(frame_words[k][31-8*b -: 8], gaps, b == 3, k, frame_words[k]);
            send_byte(model_sum(int'(len)) ^ flip, gaps, 1'b0, 0, 32'h0);
        end
        // Offer a junk byte while the loader must not be accepting.
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        @(negedge clk);
        chk1({tag, ".ready_after_last"}, rx_ready_o, 1'b0);
        chk1({tag, ".hold1"}, cpu_reset_o, 1'b1);
        @(negedge clk);
        chk1({tag, ".hold2"}, cpu_reset_o, 1'b1);
        @(negedge clk);
        rx_valid = 1'b0;
        chk1({tag, ".cpu_reset"}, cpu_reset_o, !exp_run);
        chk1({tag, ".load_done"}, load_done_o, exp_run);
        chk1({tag, ".load_err"}, load_err_o, !exp_run);
        chk1({tag, ".ready_final"}, rx_ready_o, 1'b0);
        chkw({tag, ".writes_pending"}, 32'(exp_q.size()), 32'd0);
        $display("frame %s len=%0d flip=%h gaps=%0d -> run=%0b err=%0b", tag, len, flip, gaps, load_done_o, load_err_o);
        @(posedge clk); #1;
    endtask

    task automatic do_reload(input string tag);
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        @(negedge clk);
        chk1({tag, ".reload_cpu_reset"}, cpu_reset_o, 1'b1);
        chk1({tag, ".reload_done"}, load_done_o, 1'b0);
        chk1({tag, ".reload_err"}, load_err_o, 1'b0);
        chk1({tag, ".reload_ready"}, rx_ready_o, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk1({tag, ".rx_ready"}, rx_ready_o, 1'b0);
        chk1({tag, ".imem_we"}, imem_we_o, 1'b0);
        chkw({tag, ".imem_addr"}, 32'(imem_addr_o), 32'd0);
        chkw({tag, ".imem_wdata"}, imem_wdata_o, 32'd0);
        chk1({tag, ".cpu_reset"}, cpu_reset_o, 1'b1);
        chk1({tag, ".load_done"}, load_done_o, 1'b0);
        chk1({tag, ".load_err"}, load_err_o, 1'b0);
    endtask

    initial begin
        // {len, word seed, word step, checksum flip, gaps, expect run}
        vecs[0] = '{8'd2,  32'h11223344, 32'h99999999, 8'h00, 1'b0, 1'b1};
        vecs[1] = '{8'd2,  32'h11223344, 32'h99999999, 8'h45, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 32'h0,        32'h0,        8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h21, 32'h0,        32'h0,        8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'd32, 32'h0,        32'h1,        8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'd2,  32'h11223344, 32'h99999999, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'd1,  32'hDEADBEEF, 32'h0,        8'h00, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            do_reload($sformatf("vec%0d", i));
            fill_words(vecs[i].seed, vecs[i].step);
            send_frame(vecs[i].len, vecs[i].flip, vecs[i].gaps, vecs[i].exp_run,
                       $sformatf("vec%0d", i));
        end

        // Reload and a LEN=0 byte in the same cycle: the byte must be dropped.
        do_reload("prio_pre");
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        reload   = 1'b1;
        @(posedge clk); #1;
        reload   = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        chk1("prio.load_err", load_err_o, 1'b0);
        chk1("prio.rx_ready", rx_ready_o, 1'b1);
        $display("reload priority: err=%0b ready=%0b", load_err_o, rx_ready_o);
        @(posedge clk); #1;

        // Async reset after LEN plus 5 data bytes.
        fill_words(32'h0BADF00D, 32'h01010101);
        send_byte(8'd2, 1'b0, 1'b0, 0, 32'h0);
        for (int b = 0; b < 5; b++)
            send_byte(frame_words[b/4][31-8*(b%4) -: 8], 1'b0, b == 3, b / 4, frame_words[b/4]);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_values("midrst");
        $display("reset mid-data: cpu_reset=%0b wdata=%h", cpu_reset_o, imem_wdata_o);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_words(32'hCAFE0001, 32'h00010003);
        send_frame(8'd2, 8'h00, 1'b0, 1'b1, "after_rst");

        // Reload out of RUN, then a clean reload of a new image.
        do_reload("run_reload");
        fill_words(32'h12345678, 32'h0F0F0F0F);
        send_frame(8'd3, 8'h00, 1'b1, 1'b1, "after_reload");

        // Randomized frames against the frame-level model.
        for (int r = 0; r < 8; r++) begin
            logic [7:0] len;
            logic [7:0] flip;
            bit ok_len;
            if ($urandom_range(0, 4) == 0)
                len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(DEPTH + 1, 255));
            else
                len = 8'($urandom_range(1, DEPTH));
            flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            for (int k = 0; k < DEPTH; k++) frame_words[k] = $urandom();
            ok_len = (len >= 8'd1) && (int'(len) <= DEPTH);
            do_reload($sformatf("rnd%0d", r));
            send_frame(len, flip, 1'b1, ok_len && (flip == 8'h00), $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
